// File: rtl/flash_fetch_pkg.sv
// Shared types and constants for the flash instruction fetch unit.
// Contents: FSM state enum, default buffer depth, default reset PC, word increment.
package flash_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_INC         = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries for the fetch unit.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i (ignored while full unless popping, or while flushing)
//   pop_i         : drop head entry (ignored while empty or flushing)
//   flush_i       : empty the FIFO on this edge; wins over push and pop
//   wdata_i       : 64-bit entry to write
//   count_o       : number of occupied entries
//   head_o        : entry at the head (undefined when empty)
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [63:0]      wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic [63:0]      head_o
);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, pop_eff, push_eff;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_eff  = pop_i && !flush_i && (count_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO may still accept a push.
    assign push_eff = push_i && !flush_i && (!full || pop_eff);

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (flush_i) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push_eff) wptr_d = wptr_q + PTR_W'(1);
            if (pop_eff)  rptr_d = rptr_q + PTR_W'(1);
            if (push_eff && !pop_eff) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_eff && pop_eff) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (push_eff) mem_q[wptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     flush_i || !(pop_i && (count_q == '0)));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     flush_i || !(push_i && full && !pop_i));

endmodule

// File: rtl/flash_fetch_unit.sv
// Flash instruction prefetcher: issues pipelined word reads to flash and buffers the
// returned {pc, instruction} pairs for the CPU, with flush-on-redirect.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   redirect_valid/_pc     : CPU flush request and new fetch address (bits [1:0] ignored)
//   instr_valid/_data/_pc  : head buffer entry offered to the CPU
//   instr_ready            : CPU accepts the head entry
//   mem_addr, mem_lenable  : flash read request (word aligned)
//   mem_ldata              : flash read data, one cycle after mem_lenable
module flash_fetch_unit
    import flash_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] mem_addr,
    output logic        mem_lenable,
    input  logic [31:0] mem_ldata
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      issue_pc_q, issue_pc_d;
    logic             inflight_q, inflight_d;
    logic             issue, credit;
    logic             fifo_push, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic [63:0]      fifo_head;

    // Occupied plus in-flight slots; a same-cycle pop is deliberately not counted.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit    = (occupancy < (CNT_W + 1)'(DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = 1'b0;
        issue      = 1'b0;
        if (redirect_valid) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc & ~32'h3;
        end else begin
            unique case (state_q)
                BOOT:  state_d = FETCH;
                FETCH: begin
                    if (credit) begin
                        issue      = 1'b1;
                        inflight_d = 1'b1;
                        issue_pc_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + WORD_INC;  // wraps at 2^32
                    end else begin
                        state_d = HOLD;
                    end
                end
                HOLD:    if (credit) state_d = FETCH;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Data returning during a redirect cycle belongs to a killed read.
    assign fifo_push = inflight_q && !redirect_valid;
    assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .flush_i(redirect_valid),
        .wdata_i({issue_pc_q, mem_ldata}),
        .count_o(fifo_count),
        .head_o (fifo_head)
    );

    assign mem_lenable = issue;
    assign mem_addr    = issue ? fetch_pc_q : 32'h0;
    assign instr_valid = (fifo_count != '0);
    assign instr_pc    = instr_valid ? fifo_head[63:32] : 32'h0;
    assign instr_data  = instr_valid ? fifo_head[31:0] : 32'h0;

endmodule

// File: doc/flash_fetch_unit.md
FLASH_FETCH_UNIT -- requirements
Module: flash_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of instruction buffer entries (power of 2, minimum 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  flush request from the CPU (branch or trap).
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 instr_valid  output  1  the head buffer entry is available.
REQ-008 instr_data  output  32  instruction word at the buffer head.
REQ-009 instr_pc  output  32  byte address of instr_data.
REQ-010 instr_ready  input  1  the CPU accepts the head entry when instr_valid=1.
REQ-011 mem_addr  output  32  byte address driven to flash; bits [1:0] are always 0.
REQ-012 mem_lenable  output  1  flash read strobe.
REQ-013 mem_ldata  input  32  flash read data, valid exactly 1 cycle after the cycle in which mem_lenable=1.

Function
REQ-014 SHALL implement an FSM with states BOOT, FETCH and HOLD; reset enters BOOT.
REQ-015 BOOT: no issue; SHALL move to FETCH unconditionally on the next edge.
REQ-016 Credit SHALL be defined as count + inflight < DEPTH, where count is the number of occupied buffer entries and inflight is 1 if a read was issued in the previous cycle and not killed; a same-cycle pop SHALL NOT add credit.
REQ-017 FETCH with credit available and redirect_valid=0: SHALL drive mem_lenable=1 and mem_addr=fetch_pc, and SHALL advance fetch_pc by 4 on the edge, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-018 FETCH with no credit: SHALL drive mem_lenable=0 and move to HOLD; HOLD returns to FETCH on the first cycle with credit.
REQ-019 In the cycle after an issue, SHALL push {fetch address, mem_ldata} into the buffer, unless the read was killed.
REQ-020 Reads SHALL be fully pipelined: one issue per cycle, sustained while instr_ready=1.
REQ-021 SHALL drive instr_valid high exactly when count>0; instr_data and instr_pc SHALL come from the head entry.
REQ-022 When instr_valid=1 and instr_ready=1, SHALL pop the head entry on the edge; when instr_valid=0, instr_ready SHALL have no effect.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 redirect_valid=1 in any state SHALL, on that edge, empty the buffer, kill any in-flight read, set fetch_pc=redirect_pc with bits [1:0] cleared, and enter FETCH.
REQ-025 SHALL drive mem_lenable=0 in the redirect cycle, and any pop requested in that cycle SHALL be ignored.
REQ-026 A killed read's mem_ldata SHALL never reach the buffer.
REQ-027 Redirects in consecutive cycles SHALL each be honoured; the last one wins.
REQ-028 The buffer SHALL never overflow or underflow.

Reset
REQ-029 While rst=0: mem_lenable=0, mem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, count=0, inflight=0, fetch_pc=RESET_PC, state=BOOT.
REQ-030 Reset asserted mid-operation SHALL discard all buffered and in-flight data immediately (asynchronously).
REQ-031 After rst rises: the first edge SHALL be BOOT->FETCH; in the next cycle mem_lenable=1 with mem_addr=RESET_PC; instr_valid SHALL rise 2 cycles after that issue.

Structure
REQ-032 Package flash_fetch_pkg SHALL hold the state enum (BOOT, FETCH, HOLD), the default DEPTH, the default RESET_PC and the word-increment constant 4.
REQ-033 Sub-module fetch_fifo SHALL implement a synchronous 64-bit-wide, DEPTH-entry FIFO with push, pop, flush, count and head outputs; all remaining logic stays in flash_fetch_unit.

Verification
REQ-034 Reset release with instr_ready=1 and flash preloaded with word[i]=i -> issues at 0x0, 0x4, 0x8 in consecutive cycles; instr_pc/instr_data delivered as 0/0, 4/1, 8/2 with one per cycle after 3-cycle startup.
REQ-035 instr_ready=0 held -> exactly 4 issues, then mem_lenable=0 and state=HOLD, count=4; instr_ready=1 again -> fetching resumes at 0x10 with no lost or duplicated word.
REQ-036 redirect_valid=1, redirect_pc=32'h0000_0103 while 2 entries are buffered and one read is in flight -> instr_valid=0 next cycle, next issue at 0x100, first delivered instr_pc=0x100, stale data never appears.
REQ-037 fetch_pc=32'hFFFF_FFFC -> next issue address 32'h0000_0000.
REQ-038 rst pulsed low mid-stream -> all outputs 0 asynchronously; after release, fetching restarts at RESET_PC.
REQ-039 redirect_valid and a pop in the same cycle -> count=0 afterwards and no underflow assertion fires.
